ccc_lock_sequencer: RTL and testbench

Parametrised clock-conditioning supervisor that sits beside each CCC/PLL instance in the system block. It drives the PLL reset, qualifies the PLL LOCK output with a stability filter, and releases up to NUM_CH per-clock-domain resets in a fixed staggered order. On lock loss or a forced relock it re-asserts all domain resets, pulses the PLL reset, and counts relock events. It runs on one free-running reference clock that does not depend on the PLL.

---
 rtl/ccc_lock_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ccc_lock_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_sequencer.sv
// ccc_lock_sequencer: PLL reset driver, lock qualifier and staggered
// release of per-domain resets, with relock on lock loss or request.
module ccc_lock_sequencer #(
   parameter int NUM_CH       = 4,
   parameter int ARST_PULSE   = 32,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int LOCK_FILT    = 256,
   parameter int STAGE_GAP    = 16,
   parameter int CNT_W        = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              LOCK,
   input  logic              FORCE_RELOCK,
   output logic              PLL_ARST_N,
   output logic [NUM_CH-1:0] CH_RST,
   output logic              READY,
   output logic              LOCK_LOST,
   output logic [7:0]        RELOCK_CNT,
   output logic [2:0]        STATE
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] ARST_END =
      CNT_W'(ARST_PULSE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_END =
      CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FILT_END =
      CNT_W'(LOCK_FILT - 1);
   localparam logic [CNT_W-1:0] GAP_END =
      CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_IDX =
      IDX_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

   typedef enum logic [2:0] {
      PLLRST = 3'd0,
      WAIT   = 3'd1,
      FILT   = 3'd2,
      STAGE  = 3'd3,
      RUN    = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             armed;
   logic             lock_meta;
   logic             lock_s;
   logic             loss_abort;
   logic             force_abort;
   logic             abort;
   logic [7:0]       relock_inc;

   assign STATE = state;

   // two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= LOCK;
         lock_s    <= lock_meta;
      end
   end

   // abort qualification: lock loss wins over a forced relock
   always_comb begin
      loss_abort  = 1'b0;
      force_abort = 1'b0;
      case (state)
         WAIT, FILT: begin
            force_abort = FORCE_RELOCK;
         end
         STAGE, RUN: begin
            loss_abort  = !lock_s;
            force_abort = FORCE_RELOCK && lock_s;
         end
         default: begin
            force_abort = 1'b0;
         end
      endcase
      abort = loss_abort || force_abort;
      relock_inc = (RELOCK_CNT == 8'hFF) ?
                   RELOCK_CNT : RELOCK_CNT + 8'd1;
   end

   // sequencer FSM with registered outputs; the first edge after
   // reset release only arms it, so the reset-time PLL pulse spans
   // a full ARST_PULSE cycles measured from that edge
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= PLLRST;
         cnt        <= '0;
         idx        <= '0;
         armed      <= 1'b0;
         PLL_ARST_N <= 1'b0;
         CH_RST     <= '1;
         READY      <= 1'b0;
         LOCK_LOST  <= 1'b0;
         RELOCK_CNT <= 8'd0;
      end else if (!armed) begin
         armed <= 1'b1;
      end else if (abort) begin
         state      <= PLLRST;
         cnt        <= '0;
         idx        <= '0;
         PLL_ARST_N <= 1'b0;
         CH_RST     <= '1;
         READY      <= 1'b0;
         RELOCK_CNT <= relock_inc;
         if (loss_abort) begin
            LOCK_LOST <= 1'b1;
         end
      end else begin
         case (state)
            PLLRST: begin
               if (cnt == ARST_END) begin
                  state      <= WAIT;
                  cnt        <= '0;
                  PLL_ARST_N <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT: begin
               if (lock_s) begin
                  state <= FILT;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_END) begin
                  state      <= PLLRST;
                  cnt        <= '0;
                  PLL_ARST_N <= 1'b0;
                  RELOCK_CNT <= relock_inc;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FILT: begin
               if (!lock_s) begin
                  state <= WAIT;
                  cnt   <= '0;
               end else if (cnt == FILT_END) begin
                  state <= STAGE;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STAGE: begin
               if (cnt == GAP_END) begin
                  CH_RST <= CH_RST & ~(CH_ONE << idx);
                  cnt    <= '0;
                  if (idx == LAST_IDX) begin
                     state <= RUN;
                     READY <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               READY <= 1'b1;
            end
            default: begin
               state      <= PLLRST;
               cnt        <= '0;
               idx        <= '0;
               PLL_ARST_N <= 1'b0;
               CH_RST     <= '1;
               READY      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// tb_ccc_lock_sequencer: constant vectors, corner-case sequences and
// random lock/relock stimulus against a behavioural model.
module tb_ccc_lock_sequencer;

   localparam int NUM_CH = 4;
   localparam int ARST   = 5;
   localparam int TOUT   = 100;
   localparam int LFILT  = 8;
   localparam int GAP    = 4;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       LOCK;
   logic       FORCE_RELOCK;
   logic       PLL_ARST_N;
   logic [3:0] CH_RST;
   logic       READY;
   logic       LOCK_LOST;
   logic [7:0] RELOCK_CNT;
   logic [2:0] STATE;

   always #5 CLK = ~CLK;

   ccc_lock_sequencer #(
      .NUM_CH(NUM_CH),
      .ARST_PULSE(ARST),
      .LOCK_TIMEOUT(TOUT),
      .LOCK_FILT(LFILT),
      .STAGE_GAP(GAP),
      .CNT_W(16)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .LOCK(LOCK),
      .FORCE_RELOCK(FORCE_RELOCK),
      .PLL_ARST_N(PLL_ARST_N),
      .CH_RST(CH_RST),
      .READY(READY),
      .LOCK_LOST(LOCK_LOST),
      .RELOCK_CNT(RELOCK_CNT),
      .STATE(STATE)
   );

   int vectors = 0;
   int miscompares = 0;
   int edge_n = -1;

   // behavioural model: phase, edges spent in phase, lock delay line
   int m_phase;
   int m_t;
   int m_relock;
   bit m_lost;
   bit q[$];

   typedef struct {
      int         at;
      logic       lock;
      logic       arst;
      logic [3:0] ch;
      logic       ready;
      logic       lost;
      logic [7:0] relock;
      logic [2:0] state;
   } vec_t;

   vec_t tbl[12];

   function automatic logic [17:0] pack_out(
      input logic arst, input logic [3:0] ch, input logic ready,
      input logic lost, input logic [7:0] relock,
      input logic [2:0] state);
      return {arst, ch, ready, lost, relock, state};
   endfunction

   function automatic logic [17:0] dut_out();
      return {PLL_ARST_N, CH_RST, READY, LOCK_LOST,
              RELOCK_CNT, STATE};
   endfunction

   function automatic logic [17:0] model_out();
      logic [3:0] ch;
      int n;
      n = m_t / GAP;
      if (m_phase == 3) ch = 4'hF << n;
      else if (m_phase == 4) ch = 4'h0;
      else ch = 4'hF;
      return pack_out(m_phase != 0, ch, m_phase == 4, m_lost,
                      8'(m_relock), 3'(m_phase));
   endfunction

   task automatic check(input string name,
                        input logic [17:0] exp);
      vectors++;
      if (dut_out() !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %h, expected %h",
                  name, edge_n, dut_out(), exp);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_t      = -1;
      m_relock = 0;
      m_lost   = 0;
      q        = {};
      q.push_back(1'b0);
      q.push_back(1'b0);
   endtask

   task automatic m_abort(input bit loss);
      m_phase  = 0;
      m_t      = 0;
      m_relock = (m_relock < 255) ? m_relock + 1 : 255;
      if (loss) m_lost = 1;
   endtask

   task automatic model_edge();
      bit ls;
      bit fr;
      ls = q.pop_front();
      q.push_back(LOCK === 1'b1);
      fr = (FORCE_RELOCK === 1'b1);
      case (m_phase)
         0: begin
            m_t++;
            if (m_t == ARST) begin m_phase = 1; m_t = 0; end
         end
         1: begin
            if (fr) m_abort(0);
            else if (ls) begin m_phase = 2; m_t = 0; end
            else begin
               m_t++;
               if (m_t == TOUT) begin
                  m_phase  = 0;
                  m_t      = 0;
                  m_relock = (m_relock < 255) ? m_relock + 1 : 255;
               end
            end
         end
         2: begin
            if (fr) m_abort(0);
            else if (!ls) begin m_phase = 1; m_t = 0; end
            else begin
               m_t++;
               if (m_t == LFILT) begin m_phase = 3; m_t = 0; end
            end
         end
         default: begin
            if (!ls) m_abort(1);
            else if (fr) m_abort(0);
            else if (m_phase == 3) begin
               m_t++;
               if (m_t == NUM_CH * GAP) begin
                  m_phase = 4;
                  m_t     = 0;
               end
            end
         end
      endcase
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      edge_n++;
      @(negedge CLK);
      check("model", model_out());
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) step();
   endtask

   task automatic do_reset(input logic lk);
      @(negedge CLK);
      RESET        = 1'b1;
      LOCK         = lk;
      FORCE_RELOCK = 1'b0;
      #1;
      check("reset", pack_out(0, 4'hF, 0, 0, 8'd0, 3'd0));
      model_reset();
      @(posedge CLK);
      @(negedge CLK);
      RESET  = 1'b0;
      edge_n = -1;
   endtask

   initial begin
      tbl[0]  = '{4,  1, 0, 4'hF, 0, 0, 8'd0, 3'd0};
      tbl[1]  = '{5,  1, 1, 4'hF, 0, 0, 8'd0, 3'd1};
      tbl[2]  = '{6,  1, 1, 4'hF, 0, 0, 8'd0, 3'd2};
      tbl[3]  = '{13, 1, 1, 4'hF, 0, 0, 8'd0, 3'd2};
      tbl[4]  = '{14, 1, 1, 4'hF, 0, 0, 8'd0, 3'd3};
      tbl[5]  = '{17, 1, 1, 4'hF, 0, 0, 8'd0, 3'd3};
      tbl[6]  = '{18, 1, 1, 4'hE, 0, 0, 8'd0, 3'd3};
      tbl[7]  = '{22, 1, 1, 4'hC, 0, 0, 8'd0, 3'd3};
      tbl[8]  = '{26, 1, 1, 4'h8, 0, 0, 8'd0, 3'd3};
      tbl[9]  = '{29, 1, 1, 4'h8, 0, 0, 8'd0, 3'd3};
      tbl[10] = '{30, 1, 1, 4'h0, 1, 0, 8'd0, 3'd4};
      tbl[11] = '{40, 1, 1, 4'h0, 1, 0, 8'd0, 3'd4};

      // nominal bring-up from the vector table
      do_reset(1'b1);
      for (int i = 0; i < 12; i++) begin
         LOCK = tbl[i].lock;
         run_to(tbl[i].at);
         check("nominal", pack_out(tbl[i].arst, tbl[i].ch,
               tbl[i].ready, tbl[i].lost, tbl[i].relock,
               tbl[i].state));
      end

      // three-cycle lock glitch while filtering
      do_reset(1'b1);
      run_to(7);
      LOCK = 1'b0;
      run_to(10);
      LOCK = 1'b1;
      check("glitch_wait", pack_out(1, 4'hF, 0, 0, 8'd0, 3'd1));
      run_to(36);
      check("glitch_late", pack_out(1, 4'h8, 0, 0, 8'd0, 3'd3));
      run_to(37);
      check("glitch_ready", pack_out(1, 4'h0, 1, 0, 8'd0, 3'd4));

      // lock loss in RUN, relock, then async reset mid-cycle
      do_reset(1'b1);
      run_to(32);
      LOCK = 1'b0;
      run_to(34);
      check("loss_hold", pack_out(1, 4'h0, 1, 0, 8'd0, 3'd4));
      run_to(35);
      LOCK = 1'b1;
      check("loss_abort", pack_out(0, 4'hF, 0, 1, 8'd1, 3'd0));
      run_to(64);
      check("relock_pre", pack_out(1, 4'h8, 0, 1, 8'd1, 3'd3));
      run_to(66);
      check("relock_run", pack_out(1, 4'h0, 1, 1, 8'd1, 3'd4));
      #2 RESET = 1'b1;
      #1 check("async_rst", pack_out(0, 4'hF, 0, 0, 8'd0, 3'd0));

      // forced relock mid-STAGE, second request ignored in PLLRST
      do_reset(1'b1);
      run_to(23);
      check("force_pre", pack_out(1, 4'hC, 0, 0, 8'd0, 3'd3));
      FORCE_RELOCK = 1'b1;
      step();
      FORCE_RELOCK = 1'b0;
      check("force_abort", pack_out(0, 4'hF, 0, 0, 8'd1, 3'd0));
      step();
      FORCE_RELOCK = 1'b1;
      step();
      FORCE_RELOCK = 1'b0;
      check("force_ign", pack_out(0, 4'hF, 0, 0, 8'd1, 3'd0));
      run_to(29);
      check("force_wait", pack_out(1, 4'hF, 0, 0, 8'd1, 3'd1));

      // repeated timeouts with LOCK low, counter saturation
      do_reset(1'b0);
      run_to(104);
      check("tout_pre", pack_out(1, 4'hF, 0, 0, 8'd0, 3'd1));
      run_to(105);
      check("tout_1", pack_out(0, 4'hF, 0, 0, 8'd1, 3'd0));
      run_to(109);
      check("tout_low", pack_out(0, 4'hF, 0, 0, 8'd1, 3'd0));
      run_to(110);
      check("tout_rel", pack_out(1, 4'hF, 0, 0, 8'd1, 3'd1));
      run_to(105 * 255 - 1);
      check("tout_254", pack_out(1, 4'hF, 0, 0, 8'd254, 3'd1));
      run_to(105 * 255);
      check("tout_255", pack_out(0, 4'hF, 0, 0, 8'd255, 3'd0));
      run_to(105 * 300);
      check("tout_sat", pack_out(0, 4'hF, 0, 0, 8'd255, 3'd0));

      // random lock behaviour and relock requests
      do_reset(1'b1);
      begin
         int hold;
         hold = 0;
         for (int c = 0; c < 6000; c++) begin
            if (hold == 0) begin
               LOCK = ($urandom_range(0, 9) < 8);
               hold = LOCK ? $urandom_range(5, 80)
                           : $urandom_range(1, 6);
            end
            hold--;
            FORCE_RELOCK = ($urandom_range(0, 99) == 0);
            step();
         end
         FORCE_RELOCK = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
